// File: rtl/cpu_pipe_pkg.sv
// Shared pipeline definitions for the 5-stage CPU.
// Holds the destination-field bundle carried through ID/EX, EX/MEM, MEM/WB.
package cpu_pipe_pkg;

    localparam logic [4:0] REG_ZERO = 5'd0;

    typedef struct packed {
        logic [4:0] rd;
        logic       regwr;
        logic       memrd;
    } stage_t;

    localparam stage_t BUBBLE = '{rd: REG_ZERO, regwr: 1'b0, memrd: 1'b0};

    // A write to $0 is meaningless, so it never travels down the pipe.
    function automatic stage_t normalise(stage_t s);
        stage_t r;
        r = s;
        if (s.rd == REG_ZERO) begin
            r.regwr = 1'b0;
            r.memrd = 1'b0;
        end
        return r;
    endfunction

endpackage

// File: rtl/dest_pipe_hzd_if.sv
// ID-side inputs and per-stage destination outputs of dest_pipe_hzd.
// slave is the pipeline block, master is whoever drives ID.
interface dest_pipe_hzd_if #(
    parameter int REG_W = 5,
    parameter int CNT_W = 16
);
    logic [REG_W-1:0] ID_RegRs_i;
    logic [REG_W-1:0] ID_RegRt_i;
    logic [REG_W-1:0] ID_RegRd_i;
    logic             ID_RegWr_i;
    logic             ID_MemRd_i;
    logic             Flush_i;
    logic             Stall_i;
    logic [REG_W-1:0] IDEX_RegRd_o;
    logic             IDEX_RegWr_o;
    logic             IDEX_MemRd_o;
    logic [REG_W-1:0] EXMEM_RegRd_o;
    logic             EXMEM_RegWr_o;
    logic [REG_W-1:0] MEMWB_RegRd_o;
    logic             MEMWB_RegWr_o;
    logic             PCWr_o;
    logic             IFIDWr_o;
    logic             Hazard_o;
    logic [CNT_W-1:0] HazCnt_o;

    modport slave (
        input  ID_RegRs_i, ID_RegRt_i, ID_RegRd_i,
        input  ID_RegWr_i, ID_MemRd_i, Flush_i, Stall_i,
        output IDEX_RegRd_o, IDEX_RegWr_o, IDEX_MemRd_o,
        output EXMEM_RegRd_o, EXMEM_RegWr_o,
        output MEMWB_RegRd_o, MEMWB_RegWr_o,
        output PCWr_o, IFIDWr_o, Hazard_o, HazCnt_o
    );

    modport master (
        output ID_RegRs_i, ID_RegRt_i, ID_RegRd_i,
        output ID_RegWr_i, ID_MemRd_i, Flush_i, Stall_i,
        input  IDEX_RegRd_o, IDEX_RegWr_o, IDEX_MemRd_o,
        input  EXMEM_RegRd_o, EXMEM_RegWr_o,
        input  MEMWB_RegRd_o, MEMWB_RegWr_o,
        input  PCWr_o, IFIDWr_o, Hazard_o, HazCnt_o
    );

endinterface

// File: rtl/dest_stage_reg.sv
// One pipeline stage of destination fields: hold, load, or load a bubble.
// Clears asynchronously to the bubble value.
module dest_stage_reg
    import cpu_pipe_pkg::*;
(
    input  logic   clk_i,
    input  logic   rst_i,
    input  logic   en_i,
    input  logic   bubble_i,
    input  stage_t d_i,
    output stage_t q_o
);

    stage_t q_q;
    stage_t q_d;

    always_comb begin
        q_d = q_q;
        if (en_i) begin
            q_d = bubble_i ? BUBBLE : d_i;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            q_q <= BUBBLE;
        end else begin
            q_q <= q_d;
        end
    end

    assign q_o = q_q;

endmodule

// File: rtl/dest_pipe_hzd.sv
// Destination tracking through ID/EX, EX/MEM, MEM/WB plus load-use
// interlock: freezes PC and IF/ID, bubbles ID/EX, counts interlock cycles.
module dest_pipe_hzd
    import cpu_pipe_pkg::*;
#(
    parameter int REG_W = 5,
    parameter int CNT_W = 16
) (
    input  logic           clk_i,
    input  logic           rst_i,
    dest_pipe_hzd_if.slave bus
);

    stage_t id_cap;
    stage_t idex_q;
    stage_t exmem_q;
    stage_t memwb_q;
    logic   hazard;
    logic   adv;
    logic   [CNT_W-1:0] cnt_q;
    logic   [CNT_W-1:0] cnt_d;

    always_comb begin
        id_cap.rd    = bus.ID_RegRd_i;
        id_cap.regwr = bus.ID_RegWr_i;
        id_cap.memrd = bus.ID_MemRd_i;
        id_cap       = normalise(id_cap);
    end

    // Independent of Stall_i: the dependency exists whether or not we move.
    assign hazard = idex_q.memrd && (idex_q.rd != REG_ZERO) &&
                    ((idex_q.rd == bus.ID_RegRs_i) ||
                     (idex_q.rd == bus.ID_RegRt_i));
    assign adv    = ~bus.Stall_i;

    dest_stage_reg u_idex (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .en_i    (adv),
        .bubble_i(hazard | bus.Flush_i),
        .d_i     (id_cap),
        .q_o     (idex_q)
    );

    dest_stage_reg u_exmem (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .en_i    (adv),
        .bubble_i(1'b0),
        .d_i     (idex_q),
        .q_o     (exmem_q)
    );

    dest_stage_reg u_memwb (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .en_i    (adv),
        .bubble_i(1'b0),
        .d_i     (exmem_q),
        .q_o     (memwb_q)
    );

    always_comb begin
        cnt_d = cnt_q;
        if (adv && hazard && !(&cnt_q)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign bus.IDEX_RegRd_o  = idex_q.rd;
    assign bus.IDEX_RegWr_o  = idex_q.regwr;
    assign bus.IDEX_MemRd_o  = idex_q.memrd;
    assign bus.EXMEM_RegRd_o = exmem_q.rd;
    assign bus.EXMEM_RegWr_o = exmem_q.regwr;
    assign bus.MEMWB_RegRd_o = memwb_q.rd;
    assign bus.MEMWB_RegWr_o = memwb_q.regwr;
    assign bus.Hazard_o      = hazard;
    assign bus.PCWr_o        = adv & ~hazard;
    assign bus.IFIDWr_o      = adv & ~hazard;
    assign bus.HazCnt_o      = cnt_q;

endmodule

// File: tb/tb_dest_pipe_hzd.sv
// Random and directed checks of dest_pipe_hzd against a queue-style model.
// A second instance with a 2-bit counter shares the stimulus for saturation.
module tb_dest_pipe_hzd;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    dest_pipe_hzd_if bus ();
    dest_pipe_hzd_if #(.CNT_W(2)) bus2 ();

    assign bus2.ID_RegRs_i = bus.ID_RegRs_i;
    assign bus2.ID_RegRt_i = bus.ID_RegRt_i;
    assign bus2.ID_RegRd_i = bus.ID_RegRd_i;
    assign bus2.ID_RegWr_i = bus.ID_RegWr_i;
    assign bus2.ID_MemRd_i = bus.ID_MemRd_i;
    assign bus2.Flush_i    = bus.Flush_i;
    assign bus2.Stall_i    = bus.Stall_i;

    dest_pipe_hzd dut (
        .clk_i(clk),
        .rst_i(rst),
        .bus  (bus)
    );

    dest_pipe_hzd #(.CNT_W(2)) dut2 (
        .clk_i(clk),
        .rst_i(rst),
        .bus  (bus2)
    );

    int tests = 0;
    int fails = 0;

    // Model: index 0 = ID/EX, 1 = EX/MEM, 2 = MEM/WB
    int m_rd [3];
    bit m_wr [3];
    bit m_mr [3];
    int m_cnt;
    bit m_h;

    task automatic chk(input string n, input logic [31:0] act,
                       input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d, want %0d", n, act, exp);
        end
    endtask

    function automatic bit m_haz();
        return m_mr[0] && (m_rd[0] != 0) &&
               (m_rd[0] == int'(bus.ID_RegRs_i) ||
                m_rd[0] == int'(bus.ID_RegRt_i));
    endfunction

    task automatic m_reset();
        for (int i = 0; i < 3; i++) begin
            m_rd[i] = 0;
            m_wr[i] = 0;
            m_mr[i] = 0;
        end
        m_cnt = 0;
    endtask

    always @(posedge clk) begin
        if (!rst && !bus.Stall_i) begin
            m_h = m_haz();
            m_rd[2] = m_rd[1]; m_wr[2] = m_wr[1]; m_mr[2] = m_mr[1];
            m_rd[1] = m_rd[0]; m_wr[1] = m_wr[0]; m_mr[1] = m_mr[0];
            if (m_h || bus.Flush_i || bus.ID_RegRd_i == 0) begin
                m_rd[0] = m_h || bus.Flush_i ? 0 : int'(bus.ID_RegRd_i);
                m_wr[0] = 0;
                m_mr[0] = 0;
            end else begin
                m_rd[0] = int'(bus.ID_RegRd_i);
                m_wr[0] = bus.ID_RegWr_i;
                m_mr[0] = bus.ID_MemRd_i;
            end
            if (m_h) m_cnt++;
        end
    end

    always @(negedge clk) begin
        #2;
        chk("idex_rd", 32'(bus.IDEX_RegRd_o), 32'(m_rd[0]));
        chk("idex_wr", 32'(bus.IDEX_RegWr_o), 32'(m_wr[0]));
        chk("idex_mr", 32'(bus.IDEX_MemRd_o), 32'(m_mr[0]));
        chk("exmem_rd", 32'(bus.EXMEM_RegRd_o), 32'(m_rd[1]));
        chk("exmem_wr", 32'(bus.EXMEM_RegWr_o), 32'(m_wr[1]));
        chk("memwb_rd", 32'(bus.MEMWB_RegRd_o), 32'(m_rd[2]));
        chk("memwb_wr", 32'(bus.MEMWB_RegWr_o), 32'(m_wr[2]));
        chk("hazard", 32'(bus.Hazard_o), 32'(m_haz()));
        chk("pcwr", 32'(bus.PCWr_o), 32'(!bus.Stall_i && !m_haz()));
        chk("ifidwr", 32'(bus.IFIDWr_o), 32'(!bus.Stall_i && !m_haz()));
        chk("hazcnt", 32'(bus.HazCnt_o),
            32'(m_cnt > 65535 ? 65535 : m_cnt));
        chk("hazcnt2", 32'(bus2.HazCnt_o), 32'(m_cnt > 3 ? 3 : m_cnt));
    end

    task automatic set_in(input int rs, input int rt, input int rd,
                          input bit wr, input bit mr,
                          input bit fl, input bit st);
        bus.ID_RegRs_i = 5'(rs);
        bus.ID_RegRt_i = 5'(rt);
        bus.ID_RegRd_i = 5'(rd);
        bus.ID_RegWr_i = wr;
        bus.ID_MemRd_i = mr;
        bus.Flush_i    = fl;
        bus.Stall_i    = st;
    endtask

    task automatic cyc(input int rs, input int rt, input int rd,
                       input bit wr, input bit mr,
                       input bit fl, input bit st);
        @(negedge clk);
        set_in(rs, rt, rd, wr, mr, fl, st);
        #3;
    endtask

    initial begin
        rst = 1'b1;
        m_reset();
        set_in(0, 0, 0, 0, 0, 0, 0);
        #1;
        chk("rst_idex_rd", 32'(bus.IDEX_RegRd_o), 0);
        chk("rst_hazcnt", 32'(bus.HazCnt_o), 0);
        chk("rst_pcwr", 32'(bus.PCWr_o), 1);
        chk("rst_hazard", 32'(bus.Hazard_o), 0);
        @(negedge clk);
        rst = 1'b0;

        // load-use on rs
        cyc(2, 8, 8, 1, 1, 0, 0);
        cyc(8, 1, 9, 1, 0, 0, 0);
        chk("lu_hazard", 32'(bus.Hazard_o), 1);
        chk("lu_pcwr", 32'(bus.PCWr_o), 0);
        chk("lu_ifidwr", 32'(bus.IFIDWr_o), 0);
        cyc(8, 1, 9, 1, 0, 0, 0);
        chk("lu_idex_bub", 32'(bus.IDEX_RegRd_o), 0);
        chk("lu_exmem_rd", 32'(bus.EXMEM_RegRd_o), 8);
        chk("lu_cnt", 32'(bus.HazCnt_o), 1);
        chk("lu_hazard_clr", 32'(bus.Hazard_o), 0);
        cyc(0, 0, 0, 0, 0, 0, 0);
        chk("lu_memwb_rd", 32'(bus.MEMWB_RegRd_o), 8);
        chk("lu_memwb_wr", 32'(bus.MEMWB_RegWr_o), 1);
        chk("lu_idex_add", 32'(bus.IDEX_RegRd_o), 9);

        // load to $0 then use of $0
        cyc(0, 0, 0, 1, 1, 0, 0);
        cyc(0, 0, 5, 1, 0, 0, 0);
        chk("z_hazard", 32'(bus.Hazard_o), 0);
        chk("z_idex_wr", 32'(bus.IDEX_RegWr_o), 0);
        chk("z_idex_mr", 32'(bus.IDEX_MemRd_o), 0);

        // hazard held by a 3-cycle stall
        cyc(2, 4, 4, 1, 1, 0, 0);
        repeat (3) begin
            cyc(4, 1, 6, 1, 0, 0, 1);
            chk("st_hazard", 32'(bus.Hazard_o), 1);
            chk("st_pcwr", 32'(bus.PCWr_o), 0);
            chk("st_idex_rd", 32'(bus.IDEX_RegRd_o), 4);
            chk("st_cnt", 32'(bus.HazCnt_o), 1);
        end
        cyc(4, 1, 6, 1, 0, 0, 0);
        chk("st_rel_hazard", 32'(bus.Hazard_o), 1);
        chk("st_rel_cnt", 32'(bus.HazCnt_o), 1);
        cyc(4, 1, 6, 1, 0, 0, 0);
        chk("st_bub_idex", 32'(bus.IDEX_RegRd_o), 0);
        chk("st_bub_exmem", 32'(bus.EXMEM_RegRd_o), 4);
        chk("st_bub_cnt", 32'(bus.HazCnt_o), 2);

        // flush, then flush together with a hazard
        cyc(0, 0, 0, 0, 0, 0, 0);
        cyc(1, 2, 5, 1, 0, 1, 0);
        chk("fl_pcwr", 32'(bus.PCWr_o), 1);
        cyc(0, 0, 0, 0, 0, 0, 0);
        chk("fl_idex_wr", 32'(bus.IDEX_RegWr_o), 0);
        cyc(2, 6, 6, 1, 1, 0, 0);
        cyc(6, 1, 7, 1, 0, 1, 0);
        chk("flh_hazard", 32'(bus.Hazard_o), 1);
        chk("flh_pcwr", 32'(bus.PCWr_o), 0);
        cyc(0, 0, 0, 0, 0, 0, 0);
        chk("flh_exmem", 32'(bus.EXMEM_RegRd_o), 6);
        chk("flh_cnt", 32'(bus.HazCnt_o), 3);

        // asynchronous reset with $3, $4, $7 in flight
        cyc(1, 2, 3, 1, 0, 0, 0);
        cyc(1, 2, 4, 1, 0, 0, 0);
        cyc(1, 2, 7, 1, 0, 0, 0);
        @(posedge clk);
        #2;
        chk("ar_pre_memwb", 32'(bus.MEMWB_RegRd_o), 3);
        chk("ar_pre_idex", 32'(bus.IDEX_RegRd_o), 7);
        rst = 1'b1;
        m_reset();
        set_in(0, 0, 0, 0, 0, 0, 0);
        #1;
        chk("ar_idex_rd", 32'(bus.IDEX_RegRd_o), 0);
        chk("ar_idex_wr", 32'(bus.IDEX_RegWr_o), 0);
        chk("ar_exmem_rd", 32'(bus.EXMEM_RegRd_o), 0);
        chk("ar_exmem_wr", 32'(bus.EXMEM_RegWr_o), 0);
        chk("ar_memwb_rd", 32'(bus.MEMWB_RegRd_o), 0);
        chk("ar_memwb_wr", 32'(bus.MEMWB_RegWr_o), 0);
        chk("ar_cnt", 32'(bus.HazCnt_o), 0);
        @(negedge clk);
        rst = 1'b0;
        set_in(0, 0, 10, 1, 0, 0, 0);
        #3;
        chk("ar_rel_idex", 32'(bus.IDEX_RegRd_o), 0);
        cyc(0, 0, 0, 0, 0, 0, 0);
        chk("ar_first_idex", 32'(bus.IDEX_RegRd_o), 10);

        // five load-use interlocks: 2-bit counter saturates at 3
        repeat (5) begin
            cyc(2, 1, 1, 1, 1, 0, 0);
            cyc(1, 3, 9, 1, 0, 0, 0);
        end
        cyc(0, 0, 0, 0, 0, 0, 0);
        chk("sat_cnt2", 32'(bus2.HazCnt_o), 3);
        chk("sat_cnt16", 32'(bus.HazCnt_o), 5);
        cyc(0, 0, 0, 0, 0, 0, 0);
        chk("sat_hold", 32'(bus2.HazCnt_o), 3);

        // randomized traffic over a small register set
        for (int i = 0; i < 800; i++) begin
            cyc($urandom_range(0, 7), $urandom_range(0, 7),
                $urandom_range(0, 7),
                $urandom_range(0, 9) < 7,
                $urandom_range(0, 9) < 4,
                $urandom_range(0, 9) < 1,
                $urandom_range(0, 9) < 2);
        end

        @(negedge clk);
        #4;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
